// File: rtl/sddt_cmd_arbiter_if.sv
// Command-stream bundle between the requesters, the command arbiter and the command FIFO.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface sddt_cmd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128
);
    logic [NUM_REQ*DATA_WIDTH-1:0] S_AXIS_REQ_tdata;
    logic [NUM_REQ-1:0]            S_AXIS_REQ_tvalid;
    logic [NUM_REQ-1:0]            S_AXIS_REQ_tlast;
    logic [NUM_REQ-1:0]            S_AXIS_REQ_tready;
    logic [DATA_WIDTH-1:0]         M_AXIS_CMD_tdata;
    logic                          M_AXIS_CMD_tvalid;
    logic                          M_AXIS_CMD_tlast;
    logic                          M_AXIS_CMD_tready;

    modport slave (
        input  S_AXIS_REQ_tdata, S_AXIS_REQ_tvalid, S_AXIS_REQ_tlast, M_AXIS_CMD_tready,
        output S_AXIS_REQ_tready, M_AXIS_CMD_tdata, M_AXIS_CMD_tvalid, M_AXIS_CMD_tlast
    );

    modport master (
        output S_AXIS_REQ_tdata, S_AXIS_REQ_tvalid, S_AXIS_REQ_tlast, M_AXIS_CMD_tready,
        input  S_AXIS_REQ_tready, M_AXIS_CMD_tdata, M_AXIS_CMD_tvalid, M_AXIS_CMD_tlast
    );
endinterface

// File: rtl/sddt_cmd_arbiter.sv
// Round-robin, packet-atomic merge of NUM_REQ command streams into one registered output stream.
// Optional macro SDDT_CMD_ARB_STATS_EN enables saturating per-requester completed-packet counters.
module sddt_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    sddt_cmd_arbiter_if.slave            bus,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [NUM_REQ*CNT_WIDTH-1:0] pkt_count
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] winner;
    logic                can_take;
    logic                accept;
    logic                accept_last;

    // The output register can take a new beat when it is empty or being drained this cycle.
    always_comb begin
        can_take    = !bus.M_AXIS_CMD_tvalid || bus.M_AXIS_CMD_tready;
        accept      = (state == GRANT) && bus.S_AXIS_REQ_tvalid[grant_id] && can_take;
        accept_last = accept && bus.S_AXIS_REQ_tlast[grant_id];
    end

    always_comb begin
        bus.S_AXIS_REQ_tready = '0;
        if (state == GRANT && can_take)
            bus.S_AXIS_REQ_tready[grant_id] = 1'b1;
    end

    // Search starts just past the previous winner, so every requester is at most NUM_REQ-1 packets away.
    always_comb begin
        logic found;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.S_AXIS_REQ_tvalid[(int'(last_grant) + k) % NUM_REQ]) begin
                winner = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state                 <= IDLE;
            grant_id              <= '0;
            last_grant            <= ID_WIDTH'(NUM_REQ - 1);
            bus.M_AXIS_CMD_tvalid <= 1'b0;
            bus.M_AXIS_CMD_tlast  <= 1'b0;
            bus.M_AXIS_CMD_tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.S_AXIS_REQ_tvalid) begin
                        grant_id <= winner;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept_last) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                bus.M_AXIS_CMD_tvalid <= 1'b1;
                bus.M_AXIS_CMD_tdata  <= bus.S_AXIS_REQ_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                bus.M_AXIS_CMD_tlast  <= bus.S_AXIS_REQ_tlast[grant_id];
            end else if (bus.M_AXIS_CMD_tready) begin
                bus.M_AXIS_CMD_tvalid <= 1'b0;
            end
        end
    end

    assign busy = (state == GRANT) || bus.M_AXIS_CMD_tvalid;

`ifdef SDDT_CMD_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= '0;
        end else if (accept_last && (cnt[grant_id] != {CNT_WIDTH{1'b1}})) begin
            cnt[grant_id] <= cnt[grant_id] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_sddt_cmd_arbiter.sv
// Directed self-checking bench for sddt_cmd_arbiter: queued requester sources, an output monitor,
// and one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_sddt_cmd_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 128;
    localparam int CNT_WIDTH  = 4;
    localparam int DEPTH      = 64;
`ifdef SDDT_CMD_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                         clk   = 1'b0;
    logic                         rst_n = 1'b0;
    logic [1:0]                   grant_id;
    logic                         busy;
    logic [NUM_REQ*CNT_WIDTH-1:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sddt_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    sddt_cmd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // Requester sources: per-requester beat stores, head advanced on each observed handshake.
    logic [DATA_WIDTH-1:0] src_data [NUM_REQ][DEPTH];
    logic                  src_last [NUM_REQ][DEPTH];
    int                    head [NUM_REQ] = '{default: 0};
    int                    tail [NUM_REQ] = '{default: 0};
    logic [NUM_REQ-1:0]    hs;

    always_comb begin
        bus.S_AXIS_REQ_tvalid = '0;
        bus.S_AXIS_REQ_tlast  = '0;
        bus.S_AXIS_REQ_tdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.S_AXIS_REQ_tvalid[i] = (head[i] != tail[i]);
            bus.S_AXIS_REQ_tlast[i]  = src_last[i][head[i] % DEPTH];
            bus.S_AXIS_REQ_tdata[i*DATA_WIDTH +: DATA_WIDTH] = src_data[i][head[i] % DEPTH];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            hs = bus.S_AXIS_REQ_tvalid & bus.S_AXIS_REQ_tready;
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (hs[i]) head[i]++;
        end
    end

    // Output monitor: records every beat taken by the downstream while out of reset.
    logic [DATA_WIDTH-1:0] mon_data [$];
    logic                  mon_last [$];
    int                    mon_cyc  [$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && bus.M_AXIS_CMD_tvalid && bus.M_AXIS_CMD_tready) begin
                mon_data.push_back(bus.M_AXIS_CMD_tdata);
                mon_last.push_back(bus.M_AXIS_CMD_tlast);
                mon_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int r, input logic [DATA_WIDTH-1:0] d, input logic l);
        src_data[r][tail[r] % DEPTH] = d;
        src_last[r][tail[r] % DEPTH] = l;
        tail[r]++;
    endtask

    task automatic flush();
        for (int i = 0; i < NUM_REQ; i++) tail[i] = head[i];
    endtask

    task automatic do_reset();
        flush();
        bus.M_AXIS_CMD_tready = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && mon_data.size() < n; k++) tick();
        if (mon_data.size() >= n) ok = 1'b1;
    endtask

    function automatic logic [CNT_WIDTH-1:0] cnt_of(input int r);
        return pkt_count[r*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    task automatic test_reset();
        bus.M_AXIS_CMD_tready = 1'b1;
        rst_n = 1'b0;
        tick(2);
        checks++; if (bus.M_AXIS_CMD_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus.M_AXIS_CMD_tvalid); end
        checks++; if (bus.M_AXIS_CMD_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", bus.M_AXIS_CMD_tlast); end
        checks++; if (bus.M_AXIS_CMD_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %0h want 0", bus.M_AXIS_CMD_tdata); end
        checks++; if (bus.S_AXIS_REQ_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b want 0000", bus.S_AXIS_REQ_tready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset_pkt_count got %0h want 0", pkt_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_packet();
        logic [DATA_WIDTH-1:0] exp_d [3] = '{128'h20A, 128'h20B, 128'h20C};
        logic                  exp_l [3] = '{1'b0, 1'b0, 1'b1};
        int base, c0;
        bit ok;
        do_reset();
        base = mon_data.size();
        c0   = cyc;
        for (int k = 0; k < 3; k++) push(2, exp_d[k], exp_l[k]);
        wait_beats(base + 3, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d beats want 3", mon_data.size() - base); end
        if (ok) begin
            checks++; if (mon_cyc[base] !== c0 + 3) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", mon_cyc[base], c0 + 3); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (mon_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL single_data[%0d] got %0h want %0h", k, mon_data[base+k], exp_d[k]); end
                checks++; if (mon_last[base+k] !== exp_l[k]) begin errors++; $display("FAIL single_last[%0d] got %b want %b", k, mon_last[base+k], exp_l[k]); end
                if (k > 0) begin
                    checks++; if (mon_cyc[base+k] - mon_cyc[base+k-1] !== 1) begin errors++; $display("FAIL single_gap[%0d] got %0d want 1", k, mon_cyc[base+k] - mon_cyc[base+k-1]); end
                end
            end
        end
        tick();
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id got %0d want 2", grant_id); end
        checks++; if (cnt_of(2) !== (STATS ? 4'd1 : 4'd0)) begin errors++; $display("FAIL single_pkt_count2 got %0d want %0d", cnt_of(2), STATS ? 1 : 0); end
    endtask

    task automatic test_round_robin();
        logic [DATA_WIDTH-1:0] exp_d [5] = '{128'h100, 128'h110, 128'h120, 128'h130, 128'h101};
        logic [CNT_WIDTH-1:0]  exp_c [4] = '{4'd2, 4'd1, 4'd1, 4'd1};
        int base;
        bit ok;
        do_reset();
        base = mon_data.size();
        push(0, 128'h100, 1'b1);
        push(0, 128'h101, 1'b1);
        push(1, 128'h110, 1'b1);
        push(2, 128'h120, 1'b1);
        push(3, 128'h130, 1'b1);
        wait_beats(base + 5, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d beats want 5", mon_data.size() - base); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (mon_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL rr_order[%0d] got %0h want %0h", k, mon_data[base+k], exp_d[k]); end
                if (k > 0) begin
                    checks++; if (mon_cyc[base+k] - mon_cyc[base+k-1] !== 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 2", k, mon_cyc[base+k] - mon_cyc[base+k-1]); end
                end
            end
        end
        tick();
        for (int r = 0; r < NUM_REQ; r++) begin
            checks++; if (cnt_of(r) !== (STATS ? exp_c[r] : 4'd0)) begin errors++; $display("FAIL rr_pkt_count[%0d] got %0d want %0d", r, cnt_of(r), STATS ? exp_c[r] : 4'd0); end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_WIDTH-1:0] exp_d [6] = '{128'h210, 128'h211, 128'h212, 128'h213, 128'h230, 128'h200};
        int base;
        bit ok;
        do_reset();
        base = mon_data.size();
        for (int k = 0; k < 4; k++) push(1, exp_d[k], k == 3);
        tick(2);
        push(0, 128'h200, 1'b1);
        push(3, 128'h230, 1'b1);
        bus.M_AXIS_CMD_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.M_AXIS_CMD_tvalid !== 1'b1 || bus.M_AXIS_CMD_tdata !== 128'h210 || bus.M_AXIS_CMD_tlast !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%0h l=%b want v=1 d=210 l=0", k, bus.M_AXIS_CMD_tvalid, bus.M_AXIS_CMD_tdata, bus.M_AXIS_CMD_tlast);
            end
            checks++; if (bus.S_AXIS_REQ_tready !== 4'b0000) begin errors++; $display("FAIL bp_tready[%0d] got %b want 0000", k, bus.S_AXIS_REQ_tready); end
            checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL bp_grant[%0d] got %0d want 1", k, grant_id); end
        end
        bus.M_AXIS_CMD_tready = 1'b1;
        wait_beats(base + 6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d beats want 6", mon_data.size() - base); end
        if (ok) begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (mon_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL bp_order[%0d] got %0h want %0h", k, mon_data[base+k], exp_d[k]); end
            end
        end
    endtask

    task automatic test_grant_hold();
        logic [DATA_WIDTH-1:0] exp_d [4] = '{128'h300, 128'h301, 128'h302, 128'h310};
        int base;
        bit ok;
        do_reset();
        base = mon_data.size();
        push(0, 128'h300, 1'b0);
        push(0, 128'h301, 1'b0);
        push(1, 128'h310, 1'b1);
        tick(3);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL hold_grant[%0d] got %0d want 0", k, grant_id); end
            checks++; if (bus.S_AXIS_REQ_tready !== 4'b0001) begin errors++; $display("FAIL hold_tready[%0d] got %b want 0001", k, bus.S_AXIS_REQ_tready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d] got %b want 1", k, busy); end
        end
        checks++; if (mon_data.size() !== base + 2) begin errors++; $display("FAIL hold_beats got %0d want 2", mon_data.size() - base); end
        push(0, 128'h302, 1'b1);
        wait_beats(base + 4, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got %0d beats want 4", mon_data.size() - base); end
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (mon_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL hold_order[%0d] got %0h want %0h", k, mon_data[base+k], exp_d[k]); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        bit ok;
        do_reset();
        base = mon_data.size();
        for (int k = 0; k < 4; k++) push(1, 128'h410 + k, k == 3);
        tick(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        flush();
        checks++; if (bus.M_AXIS_CMD_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", bus.M_AXIS_CMD_tvalid); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rstmid_pkt_count got %0h want 0", pkt_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_grant got %0d want 0", grant_id); end
        push(2, 128'h420, 1'b1);
        push(3, 128'h430, 1'b1);
        tick();
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL rstmid_next_grant got %0d want 2", grant_id); end
        wait_beats(base + 2, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d beats want 2", mon_data.size() - base); end
        if (ok) begin
            checks++; if (mon_data[base] !== 128'h420) begin errors++; $display("FAIL rstmid_first got %0h want 420", mon_data[base]); end
            checks++; if (mon_data[base+1] !== 128'h430) begin errors++; $display("FAIL rstmid_second got %0h want 430", mon_data[base+1]); end
        end
        tick(2);
        checks++; if (mon_data.size() !== base + 2) begin errors++; $display("FAIL rstmid_extra got %0d beats want 2", mon_data.size() - base); end
    endtask

    task automatic test_saturation();
        int base;
        bit ok;
        do_reset();
        base = mon_data.size();
        for (int p = 0; p < 17; p++) push(0, 128'h500 + p, 1'b1);
        wait_beats(base + 17, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got %0d beats want 17", mon_data.size() - base); end
        if (ok) begin
            checks++; if (mon_data[base+16] !== 128'h510) begin errors++; $display("FAIL sat_last_beat got %0h want 510", mon_data[base+16]); end
        end
        tick(2);
        checks++; if (cnt_of(0) !== (STATS ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_pkt_count0 got %0d want %0d", cnt_of(0), STATS ? 15 : 0); end
        checks++; if (pkt_count[NUM_REQ*CNT_WIDTH-1:CNT_WIDTH] !== '0) begin errors++; $display("FAIL sat_other_counts got %0h want 0", pkt_count[NUM_REQ*CNT_WIDTH-1:CNT_WIDTH]); end
    endtask

    initial begin
        bus.M_AXIS_CMD_tready = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_grant_hold();
        test_reset_mid_packet();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
